// File: rtl/async_fifo_pkg.sv
// ============================================================================
// async_fifo_pkg : Gray/binary pointer helpers shared by both FIFO controllers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package async_fifo_pkg;

   function automatic logic [31:0] width_mask(input int w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] b, input int w);
      return (b ^ (b >> 1)) & width_mask(w);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
      logic [31:0] gm;
      logic [31:0] b;
      gm    = g & width_mask(w);
      b     = '0;
      b[31] = gm[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ gm[i];
      end
      return b;
   endfunction

   // A Gray pointer one full lap ahead differs only in its top two bits.
   function automatic logic [31:0] full_cmp_mask(input logic [31:0] g, input int w);
      return (g ^ (32'd3 << (w - 2))) & width_mask(w);
   endfunction

endpackage

`default_nettype wire

// File: rtl/gray_ptr_counter.sv
// ============================================================================
// gray_ptr_counter : binary + Gray pointer register pair with increment enable.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gray_ptr_counter
   import async_fifo_pkg::*;
#(
   parameter int P = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [P-1:0] bin,
   output logic [P-1:0] bin_next,
   output logic [P-1:0] gray,
   output logic [P-1:0] gray_next
);

   logic [P-1:0] bin_q;
   logic [P-1:0] bin_d;
   logic [P-1:0] gray_q;
   logic [P-1:0] gray_d;

   always_comb begin
      bin_d  = bin_q + P'(inc);
      gray_d = P'(bin2gray(32'(bin_d), P));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q  <= '0;
         gray_q <= '0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
      end
   end

   assign bin       = bin_q;
   assign bin_next  = bin_d;
   assign gray      = gray_q;
   assign gray_next = gray_d;

endmodule

`default_nettype wire

// File: rtl/async_fifo_wr_ctrl.sv
// ============================================================================
// async_fifo_wr_ctrl : write-side pointer controller of the async FIFO.
// Optional fill level / almost_full logic: define ASYNC_FIFO_WR_LEVEL_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module async_fifo_wr_ctrl
   import async_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int AF_THRESH  = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH:0]   rd_gray_sync,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [ADDR_WIDTH:0]   wr_gray,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   wr_level,
   output logic                  overflow
);

   localparam int P = ADDR_WIDTH + 1;

   logic         push;
   logic [P-1:0] wbin;
   logic [P-1:0] wbin_next;
   logic [P-1:0] gray_next;
   logic         full_q;
   logic         full_d;
   logic         overflow_q;
   logic         overflow_d;
   logic         unused_msb;

   // The reset term keeps the strobe quiet while rst is held with wr_en high.
   assign push   = wr_en & ~full_q;
   assign mem_we = push & ~rst;

   gray_ptr_counter #(
      .P (P)
   ) u_wptr (
      .clk       (clk),
      .rst       (rst),
      .inc       (push),
      .bin       (wbin),
      .bin_next  (wbin_next),
      .gray      (wr_gray),
      .gray_next (gray_next)
   );

   assign wr_addr    = wbin[ADDR_WIDTH-1:0];
   assign unused_msb = wbin[P-1];

   always_comb begin
      full_d     = (gray_next == P'(full_cmp_mask(32'(rd_gray_sync), P)));
      overflow_d = overflow_q | (wr_en & full_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         full_q     <= full_d;
         overflow_q <= overflow_d;
      end
   end

   assign full     = full_q;
   assign overflow = overflow_q;

`ifdef ASYNC_FIFO_WR_LEVEL_EN
   localparam logic [P-1:0] AF_THRESH_P = P'(AF_THRESH);

   logic [P-1:0] rbin;
   logic [P-1:0] wr_level_d;
   logic [P-1:0] wr_level_q;
   logic         almost_full_d;
   logic         almost_full_q;

   always_comb begin
      rbin          = P'(gray2bin(32'(rd_gray_sync), P));
      wr_level_d    = wbin_next - rbin;
      almost_full_d = (wr_level_d >= AF_THRESH_P);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_level_q    <= '0;
         almost_full_q <= 1'b0;
      end else begin
         wr_level_q    <= wr_level_d;
         almost_full_q <= almost_full_d;
      end
   end

   assign wr_level    = wr_level_q;
   assign almost_full = almost_full_q;
`else
   localparam logic [P-1:0] AF_THRESH_P = P'(AF_THRESH);

   logic unused_level_inputs;

   assign unused_level_inputs = ^{AF_THRESH_P, wbin_next};
   assign wr_level            = '0;
   assign almost_full         = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_async_fifo_wr_ctrl.sv
// ============================================================================
// tb_async_fifo_wr_ctrl : directed + randomized bench with an occupancy model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_async_fifo_wr_ctrl;

   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;
   localparam int AF    = 12;
`ifdef ASYNC_FIFO_WR_LEVEL_EN
   localparam bit LVL_EN = 1'b1;
`else
   localparam bit LVL_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [AW:0]   rd_gray_sync;
   logic          mem_we;
   logic [AW-1:0] wr_addr;
   logic [AW:0]   wr_gray;
   logic          full;
   logic          almost_full;
   logic [AW:0]   wr_level;
   logic          overflow;

   int n_cmp = 0;
   int n_err = 0;

   // Occupancy model: unbounded counts of accepted writes and observed reads.
   int wtot;
   int rtot;
   bit full_m;
   bit ovf_m;

   async_fifo_wr_ctrl #(
      .ADDR_WIDTH (AW),
      .AF_THRESH  (AF)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .rd_gray_sync (rd_gray_sync),
      .mem_we       (mem_we),
      .wr_addr      (wr_addr),
      .wr_gray      (wr_gray),
      .full         (full),
      .almost_full  (almost_full),
      .wr_level     (wr_level),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [AW:0] gray_of(input int n);
      int b;
      b = n % (2 * DEPTH);
      return (AW+1)'(b ^ (b >> 1));
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".mem_we"},      32'(mem_we),      32'd0);
      check({tag, ".wr_addr"},     32'(wr_addr),     32'd0);
      check({tag, ".wr_gray"},     32'(wr_gray),     32'd0);
      check({tag, ".full"},        32'(full),        32'd0);
      check({tag, ".almost_full"}, 32'(almost_full), 32'd0);
      check({tag, ".wr_level"},    32'(wr_level),    32'd0);
      check({tag, ".overflow"},    32'(overflow),    32'd0);
   endtask

   task automatic model_reset();
      wtot         = 0;
      rtot         = 0;
      full_m       = 1'b0;
      ovf_m        = 1'b0;
      rd_gray_sync = '0;
   endtask

   // Called just after a rising edge; runs one full clock cycle.
   task automatic cycle(input bit we, input bit radv);
      bit push;
      int lvl;
      if (radv && rtot < wtot) rtot++;
      wr_en        = we;
      rd_gray_sync = gray_of(rtot);
      push         = we && !full_m;
      @(negedge clk);
      check("mem_we",  32'(mem_we),  32'(push));
      check("wr_addr", 32'(wr_addr), 32'(wtot % DEPTH));
      @(posedge clk);
      #1;
      if (push) wtot++;
      if (we && full_m) ovf_m = 1'b1;
      lvl    = wtot - rtot;
      full_m = (lvl == DEPTH);
      check("wr_gray",     32'(wr_gray),     32'(gray_of(wtot)));
      check("full",        32'(full),        32'(full_m));
      check("wr_level",    32'(wr_level),    LVL_EN ? 32'(lvl) : 32'd0);
      check("almost_full", 32'(almost_full), (LVL_EN && lvl >= AF) ? 32'd1 : 32'd0);
      check("overflow",    32'(overflow),    32'(ovf_m));
   endtask

   initial begin
      rst          = 1'b0;
      wr_en        = 1'b0;
      rd_gray_sync = '0;
      #2;
      rst   = 1'b1;
      wr_en = 1'b1;
      #1;
      check_zero("reset_async");
      @(posedge clk);
      #1;
      check_zero("reset_held");
      rst = 1'b0;
      model_reset();

      // Fill to full with no read progress.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0);
      check("fill.full",    32'(full),    32'd1);
      check("fill.wr_gray", 32'(wr_gray), 32'b11000);

      // Write while full is dropped; overflow is sticky.
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      check("ovf.sticky", 32'(overflow), 32'd1);

      // One read observed: full clears, next write lands on address 0.
      cycle(1'b0, 1'b1);
      check("rd1.full", 32'(full), 32'd0);
      cycle(1'b1, 1'b0);
      // Read advance and write together while full: write dropped.
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b0);

      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1);

      // Wrap with reads keeping pace.
      for (int i = 0; i < 40; i++) cycle(1'b1, i > 0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);

      // almost_full threshold crossing both ways.
      for (int i = 0; i < AF; i++) cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom % 4) != 0, ($urandom % 3) == 0);
      end

      for (int i = 0; i < 2 * DEPTH && rtot < wtot; i++) cycle(1'b0, 1'b1);

      // Asynchronous reset mid-burst at level 9.
      for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      check_zero("reset_mid");
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
